// File: rtl/comp_pkg.sv
// Shared definitions for the byte-serial magnitude comparator.
package comp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/comp_seq_ctrl_if.sv
// Operand/result handshake bundle for comp_seq_ctrl.
interface comp_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int IDXW = $clog2(NBYTES + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  out_valid;
    logic                  out_ready;
    logic                  G;
    logic                  E;
    logic                  L;
    logic [IDXW-1:0]       nbytes;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, G, E, L, nbytes
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, G, E, L, nbytes
    );

endinterface

// File: rtl/comp_8bit.sv
// Combinational unsigned byte comparator.
module comp_8bit
    import comp_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic              G_b,
    output logic              E_b,
    output logic              L_b
);

    assign G_b = (a > b);
    assign E_b = (a == b);
    assign L_b = (a < b);

endmodule

// File: rtl/comp_seq_ctrl.sv
// Wide unsigned compare, stepped MSB byte first through one comp_8bit,
// exiting at the first unequal byte.
module comp_seq_ctrl
    import comp_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    comp_seq_ctrl_if.slave  bus
);

    localparam int               IDXW    = $clog2(NBYTES + 1);
    localparam int               OPW     = BYTE_W * NBYTES;
    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(NBYTES - 1);
    localparam logic [IDXW-1:0]  ONE     = IDXW'(1);

    state_e              state_q, state_d;
    logic [OPW-1:0]      a_q, a_d;
    logic [OPW-1:0]      b_q, b_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW-1:0]     cnt_q, cnt_d;
    logic                g_q, g_d;
    logic                e_q, e_d;
    logic                l_q, l_d;
    logic [IDXW-1:0]     nbytes_q, nbytes_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [BYTE_W-1:0]   a_byte, b_byte;
    logic                g_b, e_b, l_b;

    assign a_byte = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
    assign b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W];

    comp_8bit u_comp (
        .a   (a_byte),
        .b   (b_byte),
        .G_b (g_b),
        .E_b (e_b),
        .L_b (l_b)
    );

    // Next-state and registered-output computation for the IDLE/CMP/DONE sequencer.
    always_comb begin
        // NOTE: every target gets a hold value first so no path infers a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        g_d         = g_q;
        e_d         = e_q;
        l_d         = l_q;
        nbytes_d    = nbytes_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    idx_d      = IDX_TOP;
                    cnt_d      = ONE;
                    in_ready_d = 1'b0;
                    state_d    = CMP;
                end
            end
            CMP: begin
                if (g_b || l_b) begin
                    g_d         = g_b;
                    l_d         = l_b;
                    e_d         = 1'b0;
                    nbytes_d    = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (e_b && (idx_q == '0)) begin
                    g_d         = 1'b0;
                    l_d         = 1'b0;
                    e_d         = 1'b1;
                    nbytes_d    = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (e_b) begin
                    idx_d = idx_q - ONE;
                    cnt_d = cnt_q + ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= IDX_TOP;
            cnt_q       <= '0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            nbytes_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            e_q         <= e_d;
            l_q         <= l_d;
            nbytes_q    <= nbytes_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand capture; contents only matter after an accept.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers, deliberately left out of reset.
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.G         = g_q;
    assign bus.E         = e_q;
    assign bus.L         = l_q;
    assign bus.nbytes    = nbytes_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Scoreboard bench for comp_seq_ctrl with NBYTES=4.
module tb_comp_seq_ctrl;

    typedef struct {
        logic g;
        logic e;
        logic l;
        int   n;
        int   acc_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    comp_seq_ctrl_if #(.NBYTES(4)) bus ();

    comp_seq_ctrl #(.NBYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard when a result appears, then checks it stays stable.
    bit             prev_ov = 1'b0;
    exp_t           cur;
    logic           hg, he, hl;
    logic [2:0]     hn;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got a result, expected none (cycle %0d)", cyc);
                end else begin
                    cur = sb.pop_front();
                    check("G", bus.G, cur.g);
                    check("E", bus.E, cur.e);
                    check("L", bus.L, cur.l);
                    check("nbytes", bus.nbytes, cur.n);
                    check("latency", cyc - cur.acc_edge, cur.n);
                end
                check("onehot", bus.G + bus.E + bus.L, 1);
                hg = bus.G; he = bus.E; hl = bus.L; hn = bus.nbytes;
            end else if (bus.out_valid && prev_ov) begin
                check("stable_GEL", {bus.G, bus.E, bus.L}, {hg, he, hl});
                check("stable_nbytes", bus.nbytes, hn);
            end
            prev_ov = bus.out_valid;
        end
    end

    // Present operands at a negedge, wait for in_ready, log the expectation at accept.
    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic eg, input logic ee, input logic el,
                        input int en, input bit push);
        int budget = 0;
        exp_t item;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("accept_within_budget", bus.in_ready, 1);
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        if (push) begin
            item.g = eg; item.e = ee; item.l = el; item.n = en; item.acc_edge = cyc + 1;
            sb.push_back(item);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (!(sb.size() == 0 && bus.in_ready && !bus.out_valid) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int budget;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_GEL", {bus.G, bus.E, bus.L}, 3'b000);
        check("rst_nbytes", bus.nbytes, 0);

        // Directed vectors, back to back
        send(32'h12345678, 32'h12345678, 0, 1, 0, 4, 1);
        send(32'h80000000, 32'h7FFFFFFF, 1, 0, 0, 1, 1);
        send(32'h12345600, 32'h12345601, 0, 0, 1, 4, 1);
        send(32'h12FF0000, 32'h12000000, 1, 0, 0, 2, 1);
        send(32'h00000000, 32'hFFFFFFFF, 0, 0, 1, 1, 1);
        send(32'h00000000, 32'h00000000, 0, 1, 0, 4, 1);
        wait_idle();

        // Busy: second operands presented during CMP must wait for IDLE
        send(32'h12345678, 32'h12345678, 0, 1, 0, 4, 1);
        send(32'h00010000, 32'h00000000, 1, 0, 0, 2, 1);
        wait_idle();

        // Backpressure
        bus.out_ready = 1'b0;
        send(32'hA0000000, 32'hA0B00000, 0, 0, 1, 2, 1);
        budget = 0;
        while (!bus.out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("bp_out_valid_rise", bus.out_valid, 1);
        repeat (6) begin
            @(negedge clk);
            check("bp_out_valid_held", bus.out_valid, 1);
            check("bp_in_ready_low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_hold_L", {bus.G, bus.E, bus.L}, 3'b001);
        check("bp_hold_nbytes", bus.nbytes, 2);

        // Reset in the middle of CMP (idx=2): op discarded
        wait_idle();
        send(32'h12345678, 32'h12345678, 0, 1, 0, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_GEL", {bus.G, bus.E, bus.L}, 3'b000);
        check("midrst_nbytes", bus.nbytes, 0);
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_result", bus.out_valid, 0);
        end
        send(32'h00000001, 32'h00000002, 0, 0, 1, 4, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
